// File: rtl/requant_pair_if.sv
// -----------------------------------------------------------------------------
// requant_pair_if
// Purpose : bundles the sample/control bus of the requant_pair block so the
//           producer (FFT side / host) and the requantizer share one port.
// Signals :
//   ce, sync_in, err_clr         control from upstream / host
//   a_re, a_im, b_re, b_im       signed IN_W channel samples, two pols
//   gain                         unsigned GAIN_W host gain (sampled at sync)
//   pol_a, pol_b                 packed {re8, im8} words toward packetizer
//   sync_out                     sync aligned with pol_a/pol_b
//   sync_err                     sticky misframed-sync flag
//   sat_cnt_a, sat_cnt_b         per-spectrum saturation counts
// Modports: master drives samples/control, slave is the requantizer.
// -----------------------------------------------------------------------------
interface requant_pair_if #(
   parameter int IN_W   = 18,
   parameter int GAIN_W = 16,
   parameter int SAT_W  = 16
);
   logic                     ce;
   logic                     sync_in;
   logic                     err_clr;
   logic signed [IN_W-1:0]   a_re;
   logic signed [IN_W-1:0]   a_im;
   logic signed [IN_W-1:0]   b_re;
   logic signed [IN_W-1:0]   b_im;
   logic [GAIN_W-1:0]        gain;
   logic [15:0]              pol_a;
   logic [15:0]              pol_b;
   logic                     sync_out;
   logic                     sync_err;
   logic [SAT_W-1:0]         sat_cnt_a;
   logic [SAT_W-1:0]         sat_cnt_b;

   modport master (
      output ce, sync_in, err_clr, a_re, a_im, b_re, b_im, gain,
      input  pol_a, pol_b, sync_out, sync_err, sat_cnt_a, sat_cnt_b
   );

   modport slave (
      input  ce, sync_in, err_clr, a_re, a_im, b_re, b_im, gain,
      output pol_a, pol_b, sync_out, sync_err, sat_cnt_a, sat_cnt_b
   );
endinterface

// File: rtl/requant_pair.sv
// -----------------------------------------------------------------------------
// requant_pair
// Purpose : per-channel requantizer ahead of the packetizer. Two complex
//           polarizations are scaled by a per-spectrum gain, rounded half up,
//           saturated symmetrically to +/-127 and packed as {re8, im8}.
//           sync is delayed to stay aligned with the packed words; spectrum
//           framing is checked on the input side.
// Ports   :
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   bus        requant_pair_if.slave (samples, gain, ce, sync, err_clr in;
//              pol_a/pol_b, sync_out, sync_err, sat_cnt_a/b out)
// Pipeline: stage 1 multiply, stage 2 round, stage 3 saturate/pack.
//           Everything advances only on ce.
// Option  : define REQUANT_STATS_EN to build the per-spectrum saturation
//           counters; otherwise sat_cnt_a/sat_cnt_b are tied to 0.
// -----------------------------------------------------------------------------

// One component lane: multiply -> round -> saturate, 3 ce-stages.
module requant_lane #(
   parameter int IN_W   = 18,
   parameter int GAIN_W = 16,
   parameter int SHIFT  = 22
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ce,
   input  logic signed [IN_W-1:0] i_x,
   input  logic [GAIN_W-1:0]      i_g,
   output logic [7:0]             o_q
`ifdef REQUANT_STATS_EN
   ,
   output logic                   o_sat_nxt
`endif
);
   localparam int P_W = IN_W + GAIN_W + 1;
   localparam int R_W = P_W - SHIFT;
   localparam logic signed [P_W-1:0] RND  = {{(P_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
   localparam logic signed [R_W-1:0] SMAX = R_W'(127);
   localparam logic signed [R_W-1:0] SMIN = R_W'(-127);

   logic signed [P_W-1:0] w_xe, w_ge, w_p, w_sum;
   logic signed [P_W-1:0] r_p;
   logic signed [R_W-1:0] w_r, r_r;
   logic                  w_hi, w_lo;
   logic [7:0]            w_q, r_q;

   // gain is unsigned: zero-extend so the signed product never sees it negative
   assign w_xe  = {{(P_W-IN_W){i_x[IN_W-1]}}, i_x};
   assign w_ge  = {{(P_W-GAIN_W){1'b0}}, i_g};
   assign w_p   = w_xe * w_ge;

   // round half up: add half an LSB, then arithmetic shift (floor)
   assign w_sum = r_p + RND;
   assign w_r   = R_W'(w_sum >>> SHIFT);

   // symmetric clip, -128 is never produced
   assign w_hi  = (r_r > SMAX);
   assign w_lo  = (r_r < SMIN);
   assign w_q   = w_hi ? 8'h7F : (w_lo ? 8'h81 : r_r[7:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p <= '0;
         r_r <= '0;
         r_q <= '0;
      end else if (ce) begin
         r_p <= w_p;
         r_r <= w_r;
         r_q <= w_q;
      end
   end

   assign o_q = r_q;
`ifdef REQUANT_STATS_EN
   // clip decision for the word about to be loaded into stage 3
   assign o_sat_nxt = w_hi | w_lo;
`endif
endmodule

module requant_pair #(
   parameter int IN_W     = 18,
   parameter int GAIN_W   = 16,
   parameter int GAIN_FRAC = 12,
   parameter int SHIFT    = 22,
   parameter int GAIN_RST = 4096,
   parameter int N_CHAN   = 2048,
   parameter int SAT_W    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   requant_pair_if.slave bus
);
   localparam int NUM_LANES = 4;   // a_re, a_im, b_re, b_im
   localparam int STAGES    = 3;
   localparam int CH_W      = $clog2(N_CHAN);

   // configuration sanity: shift must drop at least the gain fraction,
   // and channel framing relies on natural wrap of a power-of-two counter
   if (GAIN_FRAC >= SHIFT || (1 << CH_W) != N_CHAN) begin : g_cfg_chk
      $error("requant_pair: bad GAIN_FRAC/SHIFT/N_CHAN configuration");
   end

   logic [NUM_LANES-1:0][IN_W-1:0] w_x;
   logic [NUM_LANES-1:0][7:0]      w_q;
   logic [GAIN_W-1:0]              r_gain_act, w_g;
   logic                           w_sync_ce;
   logic [STAGES:1]                r_sync_pipe;
   logic [CH_W-1:0]                r_chan;
   logic                           r_locked;
   logic                           r_sync_err;
   logic                           w_bad_sync;

   assign w_x       = {bus.b_im, bus.b_re, bus.a_im, bus.a_re};
   assign w_sync_ce = bus.ce & bus.sync_in;

   // the sync sample already uses the new gain, so the whole spectrum
   // from channel 0 onward sees one consistent gain
   assign w_g = w_sync_ce ? bus.gain : r_gain_act;

`ifdef REQUANT_STATS_EN
   logic [NUM_LANES-1:0] w_sat_nxt;
`endif

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      requant_lane #(
         .IN_W   (IN_W),
         .GAIN_W (GAIN_W),
         .SHIFT  (SHIFT)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .ce        (bus.ce),
         .i_x       (w_x[gi]),
         .i_g       (w_g),
         .o_q       (w_q[gi])
`ifdef REQUANT_STATS_EN
         ,
         .o_sat_nxt (w_sat_nxt[gi])
`endif
      );
   end

   // input-side framing: chan is the index the *next* sample should carry
   assign w_bad_sync = bus.sync_in & r_locked & (r_chan != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gain_act  <= GAIN_W'(GAIN_RST);
         r_sync_pipe <= '0;
         r_chan      <= '0;
         r_locked    <= 1'b0;
         r_sync_err  <= 1'b0;
      end else if (bus.ce) begin
         r_sync_pipe <= {r_sync_pipe[STAGES-1:1], bus.sync_in};
         if (bus.sync_in) begin
            r_gain_act <= bus.gain;
            r_chan     <= CH_W'(1);
            r_locked   <= 1'b1;
         end else begin
            r_chan     <= r_chan + CH_W'(1);
         end
         // a bad sync wins over a simultaneous clear
         if (w_bad_sync)
            r_sync_err <= 1'b1;
         else if (bus.err_clr)
            r_sync_err <= 1'b0;
      end
   end

   assign bus.pol_a    = {w_q[0], w_q[1]};
   assign bus.pol_b    = {w_q[2], w_q[3]};
   assign bus.sync_out = r_sync_pipe[STAGES];
   assign bus.sync_err = r_sync_err;

`ifdef REQUANT_STATS_EN
   logic             w_flag_a, w_flag_b;
   logic [SAT_W-1:0] r_run_a, r_run_b, r_sat_cnt_a, r_sat_cnt_b;

   assign w_flag_a = w_sat_nxt[0] | w_sat_nxt[1];
   assign w_flag_b = w_sat_nxt[2] | w_sat_nxt[3];

   // Accounting happens on the edge that loads stage 3, so sat_cnt updates
   // together with sync_out and the sync word opens the new spectrum's run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run_a     <= '0;
         r_run_b     <= '0;
         r_sat_cnt_a <= '0;
         r_sat_cnt_b <= '0;
      end else if (bus.ce) begin
         if (r_sync_pipe[STAGES-1]) begin
            r_sat_cnt_a <= r_run_a;
            r_sat_cnt_b <= r_run_b;
            r_run_a     <= {{(SAT_W-1){1'b0}}, w_flag_a};
            r_run_b     <= {{(SAT_W-1){1'b0}}, w_flag_b};
         end else begin
            // sticky at all-ones, never wraps
            if (w_flag_a && (r_run_a != '1)) r_run_a <= r_run_a + SAT_W'(1);
            if (w_flag_b && (r_run_b != '1)) r_run_b <= r_run_b + SAT_W'(1);
         end
      end
   end

   assign bus.sat_cnt_a = r_sat_cnt_a;
   assign bus.sat_cnt_b = r_sat_cnt_b;
`else
   assign bus.sat_cnt_a = '0;
   assign bus.sat_cnt_b = '0;
`endif
endmodule
